// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, word/address types and register-file state enum
package mem_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DEPTH  = 16;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] raddr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file16_if.sv
// rtl/reg_file16_if.sv - write port, two read ports and busy flag of the register bank
//
// master: drives we/waddr/wdata and re_x/raddr_x, observes rdata_x/rvalid_x/busy
// slave : the register bank itself
interface reg_file16_if #(
    parameter int WIDTH  = mem_pkg::WORD_W,
    parameter int ADDR_W = mem_pkg::REG_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic              rvalid_a;

    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              rvalid_b;

    logic              busy;

    modport master (
        output we, waddr, wdata,
        output re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b, busy
    );

    modport slave (
        input  we, waddr, wdata,
        input  re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b, busy
    );

endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port with zero-word and write bypass
//
// clk_i, resn_i : clock, synchronous active-low reset
// ready_i       : bank has finished its clear sweep
// re_i, raddr_i : read request and address
// we_i, waddr_i, wdata_i : write port, observed for same-edge bypass
// mem_i         : storage contents
// rdata_o, rvalid_o : registered read data and its one-cycle valid strobe
module rf_read_port
    import mem_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int DEPTH  = REG_DEPTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              resn_i,
    input  logic              ready_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [WIDTH-1:0]  mem_i [DEPTH],
    output logic [WIDTH-1:0]  rdata_o,
    output logic              rvalid_o
);

    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // Word 0 is hardwired zero; a same-edge write wins over stale storage.
    always_comb begin
        rdata_d = mem_i[raddr_i];
        if (raddr_i == '0) begin
            rdata_d = '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resn_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (ready_i && re_i) begin
            rdata_q  <= rdata_d;
            rvalid_q <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/reg_file16.sv
// rtl/reg_file16.sv - 16x16 register bank, one write and two read ports, self-clearing after reset
//
// CLK : clock, all state changes on the rising edge
// RES : synchronous active-low reset
// bus : reg_file16_if slave (write port, read ports A/B, busy)
module reg_file16
    import mem_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int DEPTH  = REG_DEPTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic        CLK,
    input  logic        RES,
    reg_file16_if.slave bus
);

    rf_state_t         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              ready;

    assign ready = (state_q == READY);

    // The sweep visits every word once; the edge that clears the last word
    // releases the bank, and the pointer wraps back to 0 for the next reset.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else if (state_q == CLEAR) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_q <= READY;
                busy_q  <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside reset: contents are cleared by the sweep.
    always_ff @(posedge CLK) begin
        if (RES) begin
            if (state_q == CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (bus.we && (bus.waddr != '0)) begin
                mem_q[bus.waddr] <= bus.wdata;
            end
        end
    end

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
        .clk_i   (CLK),
        .resn_i  (RES),
        .ready_i (ready),
        .re_i    (bus.re_a),
        .raddr_i (bus.raddr_a),
        .we_i    (bus.we),
        .waddr_i (bus.waddr),
        .wdata_i (bus.wdata),
        .mem_i   (mem_q),
        .rdata_o (bus.rdata_a),
        .rvalid_o(bus.rvalid_a)
    );

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
        .clk_i   (CLK),
        .resn_i  (RES),
        .ready_i (ready),
        .re_i    (bus.re_b),
        .raddr_i (bus.raddr_b),
        .we_i    (bus.we),
        .waddr_i (bus.waddr),
        .wdata_i (bus.wdata),
        .mem_i   (mem_q),
        .rdata_o (bus.rdata_b),
        .rvalid_o(bus.rvalid_b)
    );

    assign bus.busy = busy_q;

endmodule

// File: tb/tb_reg_file16.sv
// tb/tb_reg_file16.sv - scoreboard bench for reg_file16
module tb_reg_file16;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b0;

    reg_file16_if rf_if ();

    reg_file16 dut (
        .CLK(clk),
        .RES(res),
        .bus(rf_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    word_t exp_a[$];
    word_t exp_b[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        rf_if.we      = 1'b0;
        rf_if.waddr   = '0;
        rf_if.wdata   = '0;
        rf_if.re_a    = 1'b0;
        rf_if.raddr_a = '0;
        rf_if.re_b    = 1'b0;
        rf_if.raddr_b = '0;
    endtask

    // One cycle of stimulus; expected read data is queued for the monitor.
    task automatic issue(input bit we, input int wa, input int wd,
                         input bit ra, input int aa, input int ea,
                         input bit rb, input int ab, input int eb);
        rf_if.we      = we;
        rf_if.waddr   = raddr_t'(wa);
        rf_if.wdata   = word_t'(wd);
        rf_if.re_a    = ra;
        rf_if.raddr_a = raddr_t'(aa);
        rf_if.re_b    = rb;
        rf_if.raddr_b = raddr_t'(ab);
        if (ra) exp_a.push_back(word_t'(ea));
        if (rb) exp_b.push_back(word_t'(eb));
        step();
        idle();
    endtask

    // Counts cycles with busy high starting at the release cycle; optionally
    // holds a write and a port-B read active throughout, which must be ignored.
    task automatic count_busy(input string name, input bit gate);
        int cnt;
        cnt = 0;
        if (gate) begin
            rf_if.we      = 1'b1;
            rf_if.waddr   = 4'd3;
            rf_if.wdata   = 16'hAAAA;
            rf_if.re_b    = 1'b1;
            rf_if.raddr_b = 4'd3;
        end
        while (rf_if.busy === 1'b1 && cnt < 40) begin
            if (gate) check("gate_rvalid_b", int'(rf_if.rvalid_b), 0);
            cnt++;
            step();
        end
        idle();
        check(name, cnt, 16);
    endtask

    task automatic hold_reset(input int n);
        res = 1'b0;
        idle();
        repeat (n) step();
        check("rst_rdata_a", int'(rf_if.rdata_a), 0);
        check("rst_rdata_b", int'(rf_if.rdata_b), 0);
        check("rst_rvalid_a", int'(rf_if.rvalid_a), 0);
        check("rst_rvalid_b", int'(rf_if.rvalid_b), 0);
        check("rst_busy", int'(rf_if.busy), 1);
        res = 1'b1;
    endtask

    // Monitor: pops an expectation whenever a port presents valid data.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rf_if.rvalid_a === 1'b1) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_rvalid_a", 1, 0);
                end else begin
                    check("rdata_a", int'(rf_if.rdata_a), int'(exp_a.pop_front()));
                end
            end
            if (rf_if.rvalid_b === 1'b1) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_rvalid_b", 1, 0);
                end else begin
                    check("rdata_b", int'(rf_if.rdata_b), int'(exp_b.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        step();

        // Reset sweep, then every word reads zero on both ports.
        hold_reset(3);
        count_busy("busy_cycles_initial", 1'b0);
        for (int i = 0; i < 16; i++) begin
            issue(0, 0, 0, 1, i, 0, 1, 15 - i, 0);
        end
        step();

        // Write then read one cycle later; valid drops, data holds.
        issue(1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 1, 5, 16'hBEEF, 0, 0, 0);
        step();
        check("hold_rvalid_a", int'(rf_if.rvalid_a), 0);
        check("hold_rdata_a", int'(rf_if.rdata_a), 16'hBEEF);

        // Same-cycle write and dual read of the same address (bypass).
        issue(1, 7, 16'h1234, 1, 7, 16'h1234, 1, 7, 16'h1234);
        issue(0, 0, 0, 1, 7, 16'h1234, 1, 5, 16'hBEEF);
        // Bypass must not leak to a different address.
        issue(1, 9, 16'h5A5A, 1, 7, 16'h1234, 1, 9, 16'h5A5A);
        issue(0, 0, 0, 1, 9, 16'h5A5A, 0, 0, 0);

        // Word 0 drops writes and always reads zero.
        issue(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 1, 0, 0, 1, 0, 0);
        issue(1, 0, 16'hFFFF, 1, 0, 0, 1, 0, 0);

        // Busy gating: preload addr 3, reset, hammer it during the sweep.
        issue(1, 3, 16'h5555, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 1, 3, 16'h5555);
        step();
        hold_reset(1);
        count_busy("busy_cycles_gated", 1'b1);
        issue(0, 0, 0, 1, 3, 0, 1, 3, 0);
        step();

        // Reset mid-sweep restarts a full sweep.
        issue(1, 12, 16'hC0DE, 0, 0, 0, 0, 0, 0);
        issue(1, 14, 16'hF00D, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 1, 12, 16'hC0DE, 1, 14, 16'hF00D);
        step();
        hold_reset(3);
        repeat (8) step();
        check("mid_busy_before", int'(rf_if.busy), 1);
        hold_reset(1);
        count_busy("busy_cycles_midsweep", 1'b0);
        issue(0, 0, 0, 1, 12, 0, 1, 14, 0);
        issue(0, 0, 0, 1, 5, 0, 1, 7, 0);
        repeat (3) step();

        check("drain_a", exp_a.size(), 0);
        check("drain_b", exp_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
